fx2_dac_streamer: RTL and testbench
===================================

Name: fx2_dac_streamer

Overview:
- Parametrised FX2LP slave-FIFO-to-DAC sample streamer in the IFCLK domain.
- Pulls bytes from the FX2 OUT endpoint and assembles them into DAC words.
- Buffers the words in an internal elastic FIFO and releases one word per programmable sample period.
- Adds three things the single-byte, unbuffered path lacks: priming, underrun counting and an idle code.

Parameters:
- FD_W, 8: FX2 data bus width (8 or 16).
- DAC_W, 16: DAC word width; must equal FD_W or 2*FD_W.
- DEPTH, 16: elastic FIFO depth in DAC words; power of two, 4..256.
- PRIME_LEVEL, 8: FIFO level required before playback starts; 1..DEPTH.
- DIV_W, 26: width of the sample-period divider.
- IDLE_CODE, 0: DAC_DATA value while idle.

Ports:
- CLK  in  1  IFCLK; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run request; low flushes the block and returns it to IDLE.
- DIV  in  DIV_W  sample period in CLK cycles; 0 is treated as 1.
- FD_IN  in  FD_W  FX2 FIFO data.
- FLAGN_EMPTY  in  1  FX2 empty flag, active low; 1 means data is available.
- SLRDN  out  1  FX2 read strobe, active low.
- SLOEN  out  1  FX2 output enable, active low.
- DAC_DATA  out  DAC_W  DAC sample.
- DAC_VALID  out  1  one-cycle strobe, high with each new DAC_DATA.
- FIFO_LEVEL  out  log2(DEPTH)+1  current word count.
- UNDERRUN_CNT  out  16  saturating underrun counter.
- STATE  out  2  00 IDLE, 01 PRIME, 10 RUN.

Behaviour:
- Reset values: SLRDN=1, SLOEN=1, DAC_DATA=IDLE_CODE, DAC_VALID=0, FIFO_LEVEL=0, UNDERRUN_CNT=0, STATE=IDLE. Byte phase, divider counter and FIFO pointers are all 0.
- SLOEN = ~ENABLE (combinational).
- SLRDN is combinational and goes low when all of the following hold: ENABLE=1, FLAGN_EMPTY=1, FIFO_LEVEL<DEPTH.
- FD_IN is captured on the same rising edge that ends the SLRDN-low cycle. Zero-latency capture; back-to-back reads are allowed every cycle.
- Byte assembly (DAC_W=2*FD_W): the first capture fills the low half and the second fills the high half.
  - The word is pushed on the edge that captures the high half.
  - When DAC_W=FD_W, every capture pushes.
  - SLRDN is also gated off for the low-half read when FIFO_LEVEL=DEPTH, so a word is never left without room to push.
- Divider: counter runs 0..max(DIV,1)-1 and produces a tick when counter==0.
  - The counter is held at 0 outside RUN.
  - If DIV is reduced so that counter ≥ DIV-1, the counter wraps to 0 on the next edge.
- State machine:
  - IDLE: when ENABLE=1, go to PRIME.
  - PRIME: reads proceed and there are no ticks. When FIFO_LEVEL ≥ PRIME_LEVEL, go to RUN.
  - RUN, tick with FIFO non-empty: pop the word. DAC_DATA takes it on the tick edge and DAC_VALID=1 for that cycle.
  - RUN, tick with FIFO empty: underrun. DAC_DATA holds its last value, DAC_VALID=0, UNDERRUN_CNT increments and saturates at 16'hFFFF. State stays RUN (no re-prime).
  - Any state with ENABLE=0: go to IDLE on the next edge. The FIFO and byte phase are flushed, DAC_DATA=IDLE_CODE, DAC_VALID=0. UNDERRUN_CNT is kept and is cleared only by reset.
- Simultaneous push and pop: FIFO_LEVEL is unchanged. A pop from a full FIFO with a push in the same cycle is legal.
- Pointers wrap modulo DEPTH. FIFO_LEVEL counts 0..DEPTH inclusive.
- RESET_N low mid-transfer forces the reset values immediately. A partial word is discarded.

Optional Feature:
- DAC_OFFSET_BINARY_EN defined: words popped from the FIFO are treated as two's complement and the MSB is inverted before they reach DAC_DATA. IDLE_CODE is output as-is.
- Not defined: FIFO words pass to DAC_DATA unchanged.

Test Plan:
- FD_W=8, DAC_W=16, DIV=4, ENABLE=1, FX2 model streams 0x01,0x02,0x03,0x04,... with FLAGN_EMPTY=1 -> state goes PRIME then RUN at level 8; DAC_DATA sequence 0x0201, 0x0403, ...; DAC_VALID every 4 cycles exactly.
- FLAGN_EMPTY=1 held, DIV=1000 -> FIFO fills to 16; SLRDN stays high while level=16; reads resume the cycle after each pop; no word lost or duplicated.
- FX2 model empties after 10 words, DIV=2 -> after 10 valid samples DAC_DATA holds the 10th word; UNDERRUN_CNT increments once per tick (reaches 5 after 10 further cycles).
- ENABLE dropped mid-stream after an odd byte count -> next edge STATE=IDLE, FIFO_LEVEL=0, DAC_DATA=IDLE_CODE. On re-enable the first word is assembled from fresh bytes with low byte first.
- DIV=0, then DIV=1 -> tick every cycle in both cases. DIV changed from 100 to 3 while counter=50 -> counter wraps to 0 the next cycle, then the period is 3.
- Compiled with DAC_OFFSET_BINARY_EN, FIFO word 0x8000 -> DAC_DATA=0x0000; FIFO word 0x7FFF -> DAC_DATA=0xFFFF.

Source files
------------

// File: rtl/fx2_dac_streamer_if.sv
// FX2 slave-FIFO and DAC-side signal bundle for fx2_dac_streamer.
// The controller (bench or host logic) uses the master modport; the streamer uses the slave modport.
interface fx2_dac_streamer_if #(
   parameter int FD_W  = 8,
   parameter int DAC_W = 16,
   parameter int DEPTH = 16,
   parameter int DIV_W = 26
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic             ENABLE;
   logic [DIV_W-1:0] DIV;
   logic [FD_W-1:0]  FD_IN;
   logic             FLAGN_EMPTY;
   logic             SLRDN;
   logic             SLOEN;
   logic [DAC_W-1:0] DAC_DATA;
   logic             DAC_VALID;
   logic [LW-1:0]    FIFO_LEVEL;
   logic [15:0]      UNDERRUN_CNT;
   logic [1:0]       STATE;

   modport master (
      output ENABLE, DIV, FD_IN, FLAGN_EMPTY,
      input  SLRDN, SLOEN, DAC_DATA, DAC_VALID, FIFO_LEVEL, UNDERRUN_CNT, STATE
   );

   modport slave (
      input  ENABLE, DIV, FD_IN, FLAGN_EMPTY,
      output SLRDN, SLOEN, DAC_DATA, DAC_VALID, FIFO_LEVEL, UNDERRUN_CNT, STATE
   );
endinterface

// File: rtl/fx2_dac_streamer.sv
// FX2LP slave-FIFO to DAC streamer: byte assembly, elastic FIFO with priming, paced playback.
// Optional macro DAC_OFFSET_BINARY_EN converts popped two's-complement words to offset binary.
module fx2_dac_streamer #(
   parameter int               FD_W        = 8,
   parameter int               DAC_W       = 16,
   parameter int               DEPTH       = 16,
   parameter int               PRIME_LEVEL = 8,
   parameter int               DIV_W       = 26,
   parameter logic [DAC_W-1:0] IDLE_CODE   = {DAC_W{1'b0}}
) (
   input logic               CLK,
   input logic               RESET_N,
   fx2_dac_streamer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PRIME = 2'b01,
      ST_RUN   = 2'b10
   } state_t;

   state_t           state_r;
   state_t           state_next;
   logic [LW-1:0]    level_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [DIV_W-1:0] cnt_r;
   logic [DIV_W-1:0] div_last_s;
   logic [DAC_W-1:0] dac_data_r;
   logic             dac_valid_r;
   logic [15:0]      underrun_r;
   logic [DAC_W-1:0] mem [DEPTH];

   logic             rd_s;
   logic             push_s;
   logic             pop_s;
   logic             tick_s;
   logic             underrun_s;
   logic [DAC_W-1:0] word_s;

   function automatic logic [DAC_W-1:0] to_dac(input logic [DAC_W-1:0] w);
`ifdef DAC_OFFSET_BINARY_EN
      return {~w[DAC_W-1], w[DAC_W-2:0]};
`else
      return w;
`endif
   endfunction

   // Reads are only issued while a full word can still be pushed; reset also parks the strobe.
   assign rd_s      = RESET_N & bus.ENABLE & bus.FLAGN_EMPTY & (level_r < LW'(DEPTH));
   assign bus.SLRDN = ~rd_s;
   assign bus.SLOEN = ~bus.ENABLE;

   generate
      if (DAC_W == 2 * FD_W) begin : g_pair
         logic            phase_r;
         logic [FD_W-1:0] low_r;

         // Low-half holding register and byte phase; a partial word is dropped on disable.
         always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
               phase_r <= 1'b0;
               low_r   <= {FD_W{1'b0}};
            end else if (!bus.ENABLE) begin
               phase_r <= 1'b0;
            end else if (rd_s) begin
               if (!phase_r) begin
                  low_r <= bus.FD_IN;
               end
               phase_r <= ~phase_r;
            end
         end

         assign push_s = rd_s & phase_r;
         assign word_s = {bus.FD_IN, low_r};
      end else begin : g_single
         assign push_s = rd_s;
         assign word_s = bus.FD_IN;
      end
   endgenerate

   assign div_last_s = (bus.DIV == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (bus.DIV - DIV_W'(1));
   assign tick_s     = bus.ENABLE & (state_r == ST_RUN) & (cnt_r == {DIV_W{1'b0}});
   assign pop_s      = tick_s & (level_r != {LW{1'b0}});
   assign underrun_s = tick_s & (level_r == {LW{1'b0}});

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next;
      end
   end

   // Next-state: prime until the FIFO holds enough words, then play without re-priming.
   always_comb begin
      state_next = state_r;
      if (!bus.ENABLE) begin
         state_next = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:  state_next = ST_PRIME;
            ST_PRIME: begin
               if (level_r >= LW'(PRIME_LEVEL)) begin
                  state_next = ST_RUN;
               end else begin
                  state_next = ST_PRIME;
               end
            end
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   // Sample-period divider; a shrunken DIV below the running count wraps it immediately.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_r <= {DIV_W{1'b0}};
      end else if (!bus.ENABLE || (state_r != ST_RUN) || (cnt_r >= div_last_s)) begin
         cnt_r <= {DIV_W{1'b0}};
      end else begin
         cnt_r <= cnt_r + DIV_W'(1);
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else if (!bus.ENABLE) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // FIFO storage.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem[wr_ptr_r] <= word_s;
      end
   end

   // DAC output register and saturating underrun counter (survives disable).
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         dac_data_r  <= IDLE_CODE;
         dac_valid_r <= 1'b0;
         underrun_r  <= 16'h0000;
      end else if (!bus.ENABLE) begin
         dac_data_r  <= IDLE_CODE;
         dac_valid_r <= 1'b0;
      end else begin
         dac_valid_r <= pop_s;
         if (pop_s) begin
            dac_data_r <= to_dac(mem[rd_ptr_r]);
         end
         if (underrun_s && (underrun_r != 16'hFFFF)) begin
            underrun_r <= underrun_r + 16'h0001;
         end
      end
   end

   assign bus.DAC_DATA     = dac_data_r;
   assign bus.DAC_VALID    = dac_valid_r;
   assign bus.FIFO_LEVEL   = level_r;
   assign bus.UNDERRUN_CNT = underrun_r;
   assign bus.STATE        = state_r;
endmodule

// File: tb/tb_fx2_dac_streamer.sv
// Directed bench for fx2_dac_streamer: table-driven start-up vectors plus hand-written corner sequences.
module tb_fx2_dac_streamer;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fx2_dac_streamer_if #(.FD_W(8), .DAC_W(16), .DEPTH(16), .DIV_W(26)) bus ();

   fx2_dac_streamer #(
      .FD_W(8), .DAC_W(16), .DEPTH(16), .PRIME_LEVEL(8), .DIV_W(26), .IDLE_CODE(16'h0000)
   ) dut (
      .CLK(clk),
      .RESET_N(rst_n),
      .bus(bus)
   );

   // FX2 OUT-endpoint model: byte k of a burst is fx_first+k, fx_limit bytes available.
   int         rd_cnt   = 0;
   int         fx_base  = 0;
   int         fx_limit = 0;
   logic [7:0] fx_first = 8'h01;
   logic       fx_on    = 1'b0;

   always @(posedge clk) begin
      if (bus.SLRDN == 1'b0) rd_cnt <= rd_cnt + 1;
   end
   assign bus.FD_IN       = 8'(rd_cnt - fx_base) + fx_first;
   assign bus.FLAGN_EMPTY = fx_on && ((rd_cnt - fx_base) < fx_limit);

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        en;
      logic [25:0] div;
      int          cyc;
      logic [1:0]  st;
      int          lvl;
      logic        vld;
      logic [15:0] dat;
   } vec_t;
   vec_t vecs [9];

   function automatic logic [15:0] xf(input logic [15:0] w);
`ifdef DAC_OFFSET_BINARY_EN
      return w ^ 16'h8000;
`else
      return w;
`endif
   endfunction

   // Expected DAC value of the n-th word (1-based) of a burst starting at byte 0x01.
   function automatic logic [15:0] wd(input int n);
      logic [7:0] hi;
      logic [7:0] lo;
      lo = 8'(2 * n - 1);
      hi = 8'(2 * n);
      return xf({hi, lo});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         step(1);
         if (bus.DAC_VALID === 1'b1) return;
      end
      total++;
      $display("FAIL %s: no DAC_VALID within %0d cycles", nm, budget);
   endtask

   task automatic restart_fx(input logic [7:0] first, input int lim);
      fx_base  = rd_cnt;
      fx_first = first;
      fx_limit = lim;
      fx_on    = 1'b1;
   endtask

   initial begin
      int         bad;
      bit         ok;
      logic [15:0] u0;
      logic [7:0] pat;

      vecs[0] = '{1'b0, 26'd4,  1, 2'b00,  0, 1'b0, 16'h0000};
      vecs[1] = '{1'b1, 26'd4,  1, 2'b01,  0, 1'b0, 16'h0000};
      vecs[2] = '{1'b1, 26'd4,  1, 2'b01,  1, 1'b0, 16'h0000};
      vecs[3] = '{1'b1, 26'd4, 14, 2'b01,  8, 1'b0, 16'h0000};
      vecs[4] = '{1'b1, 26'd4,  1, 2'b10,  8, 1'b0, 16'h0000};
      vecs[5] = '{1'b1, 26'd4,  1, 2'b10,  8, 1'b1, 16'h0201};
      vecs[6] = '{1'b1, 26'd4,  1, 2'b10,  8, 1'b0, 16'h0201};
      vecs[7] = '{1'b1, 26'd4,  3, 2'b10,  9, 1'b1, 16'h0403};
      vecs[8] = '{1'b1, 26'd4,  4, 2'b10, 10, 1'b1, 16'h0605};

      rst_n      = 1'b0;
      bus.ENABLE = 1'b0;
      bus.DIV    = 26'd4;
      restart_fx(8'h01, 100000);
      step(2);
      chk("rst_slrdn", 32'(bus.SLRDN), 32'd1);
      chk("rst_sloen", 32'(bus.SLOEN), 32'd1);
      chk("rst_underrun", 32'(bus.UNDERRUN_CNT), 32'd0);
      rst_n = 1'b1;

      // Start-up: prime to level 8, then one word every 4 cycles.
      for (int i = 0; i < 9; i++) begin
         bus.ENABLE = vecs[i].en;
         bus.DIV    = vecs[i].div;
         step(vecs[i].cyc);
         chk($sformatf("t1_state[%0d]", i), 32'(bus.STATE), 32'(vecs[i].st));
         chk($sformatf("t1_level[%0d]", i), 32'(bus.FIFO_LEVEL), 32'(vecs[i].lvl));
         chk($sformatf("t1_valid[%0d]", i), 32'(bus.DAC_VALID), 32'(vecs[i].vld));
         chk($sformatf("t1_data[%0d]", i), 32'(bus.DAC_DATA),
             32'((vecs[i].dat == 16'h0000) ? 16'h0000 : xf(vecs[i].dat)));
      end
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk("t1_valid_period", 32'(bus.DAC_VALID), (k % 4 == 0) ? 32'd1 : 32'd0);
         if (k % 4 == 0) chk("t1_data_seq", 32'(bus.DAC_DATA), 32'(wd(3 + k / 4)));
      end
      bus.ENABLE = 1'b0;
      step(1);
      chk("t1_off_state", 32'(bus.STATE), 32'd0);
      chk("t1_off_level", 32'(bus.FIFO_LEVEL), 32'd0);
      chk("t1_off_data", 32'(bus.DAC_DATA), 32'h0000);

      // Disable after an odd byte count, then restart from fresh bytes.
      restart_fx(8'h01, 100000);
      bus.ENABLE = 1'b1;
      bus.DIV    = 26'd1000;
      step(3);
      chk("t4_level_pre", 32'(bus.FIFO_LEVEL), 32'd1);
      bus.ENABLE = 1'b0;
      step(1);
      chk("t4_state", 32'(bus.STATE), 32'd0);
      chk("t4_level", 32'(bus.FIFO_LEVEL), 32'd0);
      chk("t4_data", 32'(bus.DAC_DATA), 32'h0000);
      chk("t4_valid", 32'(bus.DAC_VALID), 32'd0);
      chk("t4_slrdn", 32'(bus.SLRDN), 32'd1);
      chk("t4_sloen", 32'(bus.SLOEN), 32'd1);
      restart_fx(8'hA0, 100000);
      bus.ENABLE = 1'b1;
      bus.DIV    = 26'd1;
      wait_valid(40, "t4_first_valid");
      chk("t4_fresh_word", 32'(bus.DAC_DATA), 32'(xf(16'hA1A0)));
      bus.ENABLE = 1'b0;
      step(1);

      // Fill to DEPTH with a slow divider; reads resume right after each pop.
      restart_fx(8'h01, 100000);
      bus.ENABLE = 1'b1;
      bus.DIV    = 26'd1000;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         step(1);
         if (bus.FIFO_LEVEL == 5'd16) ok = 1'b1;
      end
      chk("t2_fill_reached", 32'(ok), 32'd1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.FIFO_LEVEL != 5'd16 || bus.SLRDN != 1'b1) bad++;
      end
      chk("t2_hold_full", 32'(bad), 32'd0);
      wait_valid(1100, "t2_pop");
      chk("t2_pop_level", 32'(bus.FIFO_LEVEL), 32'd15);
      chk("t2_pop_slrdn", 32'(bus.SLRDN), 32'd0);
      chk("t2_pop_data", 32'(bus.DAC_DATA), 32'(wd(2)));
      step(2);
      chk("t2_refill_level", 32'(bus.FIFO_LEVEL), 32'd16);
      chk("t2_refill_slrdn", 32'(bus.SLRDN), 32'd1);
      bus.DIV = 26'd2;
      for (int n = 3; n <= 22; n++) begin
         wait_valid(10, "t2_drain_valid");
         chk($sformatf("t2_word[%0d]", n), 32'(bus.DAC_DATA), 32'(wd(n)));
      end
      bus.ENABLE = 1'b0;
      step(1);

      // Source runs dry after 10 words: hold last word and count underruns.
      u0 = bus.UNDERRUN_CNT;
      restart_fx(8'h01, 20);
      bus.ENABLE = 1'b1;
      bus.DIV    = 26'd2;
      for (int n = 1; n <= 10; n++) begin
         wait_valid(40, "t3_valid");
         chk($sformatf("t3_word[%0d]", n), 32'(bus.DAC_DATA), 32'(wd(n)));
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (bus.DAC_VALID !== 1'b0) bad++;
      end
      chk("t3_no_valid", 32'(bad), 32'd0);
      chk("t3_underrun", 32'(bus.UNDERRUN_CNT - u0), 32'd5);
      chk("t3_hold_data", 32'(bus.DAC_DATA), 32'(wd(10)));
      chk("t3_state_run", 32'(bus.STATE), 32'd2);
      bus.ENABLE = 1'b0;
      step(1);
      chk("t3_underrun_kept", 32'(bus.UNDERRUN_CNT), 32'(u0 + 16'd5));

      // DIV 0 and 1 tick every cycle; DIV 100 -> 3 with the counter at 50.
      restart_fx(8'h01, 100000);
      bus.ENABLE = 1'b1;
      bus.DIV    = 26'd0;
      wait_valid(40, "t5_first_valid");
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (bus.DAC_VALID !== 1'b1) bad++;
      end
      chk("t5_div0_every_cycle", 32'(bad), 32'd0);
      bus.DIV = 26'd1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (bus.DAC_VALID !== 1'b1) bad++;
      end
      chk("t5_div1_every_cycle", 32'(bad), 32'd0);
      bus.DIV = 26'd100;
      step(1);
      chk("t5_div100_first", 32'(bus.DAC_VALID), 32'd1);
      bad = 0;
      for (int i = 0; i < 49; i++) begin
         step(1);
         if (bus.DAC_VALID !== 1'b0) bad++;
      end
      chk("t5_div100_quiet", 32'(bad), 32'd0);
      bus.DIV = 26'd3;
      pat = 8'b1001_0010;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk($sformatf("t5_div3_wrap[%0d]", i), 32'(bus.DAC_VALID), 32'(pat[i]));
      end

      // Asynchronous reset mid-stream.
      rst_n = 1'b0;
      #1;
      chk("rst_mid_state", 32'(bus.STATE), 32'd0);
      chk("rst_mid_level", 32'(bus.FIFO_LEVEL), 32'd0);
      chk("rst_mid_valid", 32'(bus.DAC_VALID), 32'd0);
      chk("rst_mid_data", 32'(bus.DAC_DATA), 32'h0000);
      chk("rst_mid_underrun", 32'(bus.UNDERRUN_CNT), 32'd0);
      chk("rst_mid_slrdn", 32'(bus.SLRDN), 32'd1);
      step(2);
      bus.ENABLE = 1'b0;
      rst_n      = 1'b1;
      step(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
